// File: rtl/ramblock_pkg.sv
// ramblock_pkg
// Shared definitions for the parametrised RAM-block FIFO:
//   - default data/address widths (9-bit words, 256 deep)
//   - par_ok(): parity check of a stored word against the selected sense
//   - cnt_w():  width of the occupancy counter for a given address width
package ramblock_pkg;

    localparam int DEF_DW = 9;
    localparam int DEF_AW = 8;

    // Widest word par_ok() can check. Narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int MAX_DW = 64;

    // 1 when the ones-count parity of word matches the sense (1 odd, 0 even).
    function automatic logic par_ok(input logic [MAX_DW-1:0] word, input logic odd);
        return (^word) == odd;
    endfunction

    // The counter must hold 0..2**aw inclusive, hence one extra bit.
    function automatic int cnt_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/sdp_ram_array.sv
// sdp_ram_array
// Simple-dual-port RAM: one write port and one registered read port on a
// single clock. The array has no reset. A read and a write to the same
// address in the same cycle return the old contents (read-before-write),
// which the FIFO relies on when it is full and reads/writes together.
// Ports:
//   clk    in  clock, rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable; rdata updates only when re is high
//   raddr  in  read address
//   rdata  out registered read data
module sdp_ram_array #(
    parameter int DW = 9,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_ramblock_sync_param.sv
// fifo_ramblock_sync_param
// Single-clock FIFO around one sdp_ram_array, with threshold flags,
// optional extra output register, parity generation/check and
// overflow/underflow pulses.
// Ports:
//   CLKS    in   clock, all logic rising-edge
//   RSTB    in   async active-low reset
//   DIn     in   write data (MSB is the parity slot)
//   WRB     in   active-low write strobe
//   RDB     in   active-low read strobe
//   PARGEN  in   1: generate parity into DIn[DW-1] on write
//   PAROOD  in   parity sense, 1 odd / 0 even, over all DW bits
//   THRESH  in   level threshold 0..2**AW
//   DO      out  read data, holds last value when DVAL=0
//   DVAL    out  one-cycle pulse per accepted read
//   FULL    out  level == 2**AW (registered)
//   EMPTY   out  level == 0 (registered)
//   EQTH    out  level == THRESH (combinational)
//   GEQTH   out  level >= THRESH (combinational)
//   WPE     out  write parity error pulse
//   RPE     out  read parity error pulse, aligned with DVAL
//   OVF     out  write rejected because full
//   UDF     out  read rejected because empty
//
// Handshake: a strobe low on a rising edge is a request. A read request is
// accepted when EMPTY=0; a write request is accepted when FULL=0 or a read
// is accepted on the same edge. There is no back-pressure wait: a rejected
// request is dropped and flagged by OVF/UDF on the next cycle. Each accepted
// read produces exactly one DVAL pulse 1+PIPE cycles later.
module fifo_ramblock_sync_param
    import ramblock_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int PIPE = 0
) (
    input  logic          CLKS,
    input  logic          RSTB,
    input  logic [DW-1:0] DIn,
    input  logic          WRB,
    input  logic          RDB,
    input  logic          PARGEN,
    input  logic          PAROOD,
    input  logic [AW:0]   THRESH,
    output logic [DW-1:0] DO,
    output logic          DVAL,
    output logic          FULL,
    output logic          EMPTY,
    output logic          EQTH,
    output logic          GEQTH,
    output logic          WPE,
    output logic          RPE,
    output logic          OVF,
    output logic          UDF
);

    localparam int CW = cnt_w(AW);
    localparam logic [CW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          full_q;
    logic          empty_q;
    logic          rd_acc;
    logic          wr_acc;
    logic [DW-1:0] wdata;
    logic          din_par_bad;
    logic [DW-1:0] ram_rdata;
    logic          ram_v;       // ram_rdata holds a freshly read word
    logic [DW-1:0] stage_data;  // word entering the DO register
    logic          stage_v;

    // Acceptance uses the registered flags, so no write-to-read fall-through.
    assign rd_acc = !RDB && !empty_q;
    assign wr_acc = !WRB && (!full_q || rd_acc);

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    // With PARGEN the incoming MSB is replaced by the bit that makes the
    // whole word's parity match PAROOD.
    always_comb begin
        wdata = DIn;
        if (PARGEN) begin
            wdata[DW-1] = (^DIn[DW-2:0]) ^ PAROOD;
        end
    end

    assign din_par_bad = !par_ok(MAX_DW'(DIn), PAROOD);

    sdp_ram_array #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk   (CLKS),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLKS or negedge RSTB) begin
        if (!RSTB) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            OVF     <= 1'b0;
            UDF     <= 1'b0;
            WPE     <= 1'b0;
            ram_v   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == DEPTH);
            empty_q <= (count_nxt == '0);
            OVF     <= !WRB && !wr_acc;
            UDF     <= !RDB && empty_q;
            WPE     <= wr_acc && !PARGEN && din_par_bad;
            ram_v   <= rd_acc;
        end
    end

    // Optional extra register between the RAM read port and DO.
    generate
        if (PIPE != 0) begin : g_pipe
            logic [DW-1:0] s2_data;
            logic          s2_v;

            always_ff @(posedge CLKS or negedge RSTB) begin
                if (!RSTB) begin
                    s2_data <= '0;
                    s2_v    <= 1'b0;
                end else begin
                    s2_v <= ram_v;
                    if (ram_v) begin
                        s2_data <= ram_rdata;
                    end
                end
            end

            assign stage_data = s2_data;
            assign stage_v    = s2_v;
        end else begin : g_nopipe
            assign stage_data = ram_rdata;
            assign stage_v    = ram_v;
        end
    endgenerate

    // DO only loads on a valid word so it holds between reads; RPE is
    // judged on the word actually presented, whatever PARGEN was.
    always_ff @(posedge CLKS or negedge RSTB) begin
        if (!RSTB) begin
            DO   <= '0;
            DVAL <= 1'b0;
            RPE  <= 1'b0;
        end else begin
            DVAL <= stage_v;
            RPE  <= stage_v && !par_ok(MAX_DW'(stage_data), PAROOD);
            if (stage_v) begin
                DO <= stage_data;
            end
        end
    end

    assign FULL  = full_q;
    assign EMPTY = empty_q;
    assign EQTH  = (count == THRESH);
    assign GEQTH = (count >= THRESH);

endmodule

// File: tb/tb_fifo_ramblock_sync_param.sv
// tb_fifo_ramblock_sync_param
// Two instances (PIPE=0 and PIPE=1) share one stimulus stream. A queue-based
// reference FIFO predicts flags and read data; per-instance monitors compare
// every DVAL word, its parity flag and its arrival cycle against the
// expected queues, and check that DO holds between reads.
module tb_fifo_ramblock_sync_param;

    localparam int DW    = 9;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int EW    = 32 + 1 + DW;  // {due cycle, rpe, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstb   = 1'b0;
    logic [DW-1:0] din    = '0;
    logic          wrb    = 1'b1;
    logic          rdb    = 1'b1;
    logic          pargen = 1'b1;
    logic          parood = 1'b1;
    logic [AW:0]   thresh = 4'd4;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic [DW-1:0] do0, do1;
    logic dval0, full0, empty0, eqth0, geqth0, wpe0, rpe0, ovf0, udf0;
    logic dval1, full1, empty1, eqth1, geqth1, wpe1, rpe1, ovf1, udf1;

    fifo_ramblock_sync_param #(.DW(DW), .AW(AW), .PIPE(0)) dut0 (
        .CLKS(clk), .RSTB(rstb), .DIn(din), .WRB(wrb), .RDB(rdb),
        .PARGEN(pargen), .PAROOD(parood), .THRESH(thresh),
        .DO(do0), .DVAL(dval0), .FULL(full0), .EMPTY(empty0),
        .EQTH(eqth0), .GEQTH(geqth0), .WPE(wpe0), .RPE(rpe0),
        .OVF(ovf0), .UDF(udf0)
    );

    fifo_ramblock_sync_param #(.DW(DW), .AW(AW), .PIPE(1)) dut1 (
        .CLKS(clk), .RSTB(rstb), .DIn(din), .WRB(wrb), .RDB(rdb),
        .PARGEN(pargen), .PAROOD(parood), .THRESH(thresh),
        .DO(do1), .DVAL(dval1), .FULL(full1), .EMPTY(empty1),
        .EQTH(eqth1), .GEQTH(geqth1), .WPE(wpe1), .RPE(rpe1),
        .OVF(ovf1), .UDF(udf1)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [DW-1:0] model_q[$];   // reference FIFO contents (stored words)
    logic [DW-1:0] last_do0 = '0;
    logic [DW-1:0] last_do1 = '0;
    logic [EW-1:0] e0, e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] stored_word(input logic [DW-1:0] d);
        logic [DW-1:0] w;
        w = d;
        if (pargen) w[DW-1] = (^d[DW-2:0]) ^ parood;
        return w;
    endfunction

    function automatic logic bad_par(input logic [DW-1:0] w);
        return (^w) != parood;
    endfunction

    // Monitors: outputs only change on posedge, so sample on negedge.
    always @(negedge clk) begin
        if (dval0) begin
            if (exp_q0.size() == 0) begin
                check("dval0_spurious", 32'(dval0), 32'd0);
            end else begin
                e0 = exp_q0.pop_front();
                check("data0", 32'({rpe0, do0}), 32'(e0[DW:0]));
                check("lat0", cyc, e0[EW-1 -: 32]);
                last_do0 = e0[DW-1:0];
            end
        end else begin
            check("hold0", 32'({rpe0, do0}), 32'({1'b0, last_do0}));
        end
    end

    always @(negedge clk) begin
        if (dval1) begin
            if (exp_q1.size() == 0) begin
                check("dval1_spurious", 32'(dval1), 32'd0);
            end else begin
                e1 = exp_q1.pop_front();
                check("data1", 32'({rpe1, do1}), 32'(e1[DW:0]));
                check("lat1", cyc, e1[EW-1 -: 32]);
                last_do1 = e1[DW-1:0];
            end
        end else begin
            check("hold1", 32'({rpe1, do1}), 32'({1'b0, last_do1}));
        end
    end

    // ---------------- driver tasks ----------------
    // One clock of stimulus; flags {FULL,EMPTY,EQTH,GEQTH,OVF,UDF,WPE} are
    // predicted from the reference queue and checked after the edge.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
        logic          rd_acc, wr_acc;
        logic [DW-1:0] r;
        logic [6:0]    exp_f;
        int            cnt;
        @(negedge clk);
        wrb = ~wr;
        rdb = ~rd;
        din = d;
        rd_acc = rd && (model_q.size() > 0);
        wr_acc = wr && ((model_q.size() < DEPTH) || rd_acc);
        if (rd_acc) begin
            r = model_q.pop_front();
            exp_q0.push_back({cyc + 32'd2, bad_par(r), r});
            exp_q1.push_back({cyc + 32'd3, bad_par(r), r});
        end
        if (wr_acc) model_q.push_back(stored_word(d));
        cnt = model_q.size();
        exp_f = {cnt == DEPTH, cnt == 0, cnt == int'(thresh), cnt >= int'(thresh),
                 wr && !wr_acc, rd && !rd_acc, wr_acc && !pargen && bad_par(d)};
        @(posedge clk);
        #1;
        check("flags0", 32'({full0, empty0, eqth0, geqth0, ovf0, udf0, wpe0}), 32'(exp_f));
        check("flags1", 32'({full1, empty1, eqth1, geqth1, ovf1, udf1, wpe1}), 32'(exp_f));
    endtask

    // Asserts reset just after a negedge (monitors have already sampled) and
    // checks the async clear before any further clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rstb = 1'b0;
        wrb  = 1'b1;
        rdb  = 1'b1;
        #1;
        check("rst0", 32'({full0, empty0, dval0, ovf0, udf0, wpe0, rpe0, do0}), 32'({7'b0100000, 9'h000}));
        check("rst1", 32'({full1, empty1, dval1, ovf1, udf1, wpe1, rpe1, do1}), 32'({7'b0100000, 9'h000}));
        model_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        last_do0 = '0;
        last_do1 = '0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) thresh = (AW+1)'($urandom_range(0, DEPTH));
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DW'($urandom_range(0, 511)));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        step(1'b0, 1'b0, '0);  // empty after release

        // fill, overflow, drain with one extra read (underflow)
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 9'h055);
        for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, '0);
        idle(3);

        // threshold crossings around THRESH=4
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 511)));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
        idle(2);

        // read+write while full, across pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DW'(8'h20 + i));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
        idle(2);

        // read+write while empty: write only, underflow
        step(1'b1, 1'b1, 9'h011);
        step(1'b0, 1'b1, '0);
        idle(3);

        // parity generate then parity error path
        step(1'b1, 1'b0, 9'h003);
        step(1'b0, 1'b1, '0);
        idle(3);
        pargen = 1'b0;
        step(1'b1, 1'b0, 9'h003);
        step(1'b0, 1'b1, '0);
        idle(3);
        pargen = 1'b1;

        // random traffic, then reset with a read in flight
        rand_phase(300);
        step(1'b1, 1'b1, 9'h0a5);
        do_reset();
        step(1'b0, 1'b0, '0);

        // random traffic, raw writes with even parity sense
        pargen = 1'b0;
        parood = 1'b0;
        rand_phase(250);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, '0);
        idle(4);

        check("leftover0", exp_q0.size(), 32'd0);
        check("leftover1", exp_q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
